disp_scan: RTL and testbench

- Parametrised, time-multiplexed driver for a multi-digit common-cathode 7-segment display. Successor to the single-digit decoder.
- Latches a packed nibble vector and scans one digit per slot with an anti-ghosting blank interval.
- Adds hex/decimal mode, leading-zero blanking and per-digit decimal points.
- Applies new values only at frame boundaries, so no digit ever shows a mix of old and new data.

---
 rtl/disp_pkg.sv | 33 +++
 rtl/disp_scan_decode.sv | 36 +++
 rtl/disp_scan.sv | 169 ++++++++++++++++
 tb/tb_disp_scan.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are {a,b,c,d,e,f,g,dp}, active-high, with dp clear.
package disp_pkg;

    localparam logic [7:0] SEG_0   = 8'hFC;
    localparam logic [7:0] SEG_1   = 8'h60;
    localparam logic [7:0] SEG_2   = 8'hDA;
    localparam logic [7:0] SEG_3   = 8'hF2;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'hB6;
    localparam logic [7:0] SEG_6   = 8'hBE;
    localparam logic [7:0] SEG_7   = 8'hE0;
    localparam logic [7:0] SEG_8   = 8'hFE;
    localparam logic [7:0] SEG_9   = 8'hF6;
    localparam logic [7:0] SEG_A   = 8'hEE;
    localparam logic [7:0] SEG_B   = 8'h3E;
    localparam logic [7:0] SEG_C   = 8'h9C;
    localparam logic [7:0] SEG_D   = 8'h7A;
    localparam logic [7:0] SEG_E   = 8'h9E;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Bit positions inside the segment byte.
    localparam int SEG_BIT_A  = 7;
    localparam int SEG_BIT_B  = 6;
    localparam int SEG_BIT_C  = 5;
    localparam int SEG_BIT_D  = 4;
    localparam int SEG_BIT_E  = 3;
    localparam int SEG_BIT_F  = 2;
    localparam int SEG_BIT_G  = 1;
    localparam int SEG_BIT_DP = 0;

endpackage

// File: rtl/disp_scan_decode.sv
// Combinational nibble-to-segment decoder (segments a..g only).
// Values 10..15 show as A b C d E F in hex mode and stay dark otherwise.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_mode_i,
    output logic [7:1] seg_o
);

    // Map the nibble to its a..g pattern.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        seg_o = SEG_OFF[SEG_BIT_A:SEG_BIT_G];
        case (nibble_i)
            4'h0: seg_o = SEG_0[SEG_BIT_A:SEG_BIT_G];
            4'h1: seg_o = SEG_1[SEG_BIT_A:SEG_BIT_G];
            4'h2: seg_o = SEG_2[SEG_BIT_A:SEG_BIT_G];
            4'h3: seg_o = SEG_3[SEG_BIT_A:SEG_BIT_G];
            4'h4: seg_o = SEG_4[SEG_BIT_A:SEG_BIT_G];
            4'h5: seg_o = SEG_5[SEG_BIT_A:SEG_BIT_G];
            4'h6: seg_o = SEG_6[SEG_BIT_A:SEG_BIT_G];
            4'h7: seg_o = SEG_7[SEG_BIT_A:SEG_BIT_G];
            4'h8: seg_o = SEG_8[SEG_BIT_A:SEG_BIT_G];
            4'h9: seg_o = SEG_9[SEG_BIT_A:SEG_BIT_G];
            4'hA: if (hex_mode_i) seg_o = SEG_A[SEG_BIT_A:SEG_BIT_G];
            4'hB: if (hex_mode_i) seg_o = SEG_B[SEG_BIT_A:SEG_BIT_G];
            4'hC: if (hex_mode_i) seg_o = SEG_C[SEG_BIT_A:SEG_BIT_G];
            4'hD: if (hex_mode_i) seg_o = SEG_D[SEG_BIT_A:SEG_BIT_G];
            4'hE: if (hex_mode_i) seg_o = SEG_E[SEG_BIT_A:SEG_BIT_G];
            4'hF: if (hex_mode_i) seg_o = SEG_F[SEG_BIT_A:SEG_BIT_G];
            default: seg_o = SEG_OFF[SEG_BIT_A:SEG_BIT_G];
        endcase
    end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed multi-digit common-cathode 7-segment driver.
// Each digit slot starts with a dark interval to stop ghosting; new data
// is swapped in only at frame boundaries so a frame never mixes values.
module disp_scan
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LIT  = PRE_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan position
    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    logic [IDX_W-1:0] index_q, index_d;

    // Displayed data and the copy waiting for the next frame boundary
    logic [4*NUM_DIGITS-1:0] active_val_q;
    logic [NUM_DIGITS-1:0]   active_dp_q;
    logic [4*NUM_DIGITS-1:0] pend_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic                    pend_flag_q;

    // Registered outputs
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_done_q;

    logic       slot_end;
    logic       frame_end;
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       lz_hit;
    logic [7:1] dec_seg;

    assign slot_end  = en && (prescaler_q == PRE_LAST);
    assign frame_end = slot_end && (index_q == IDX_LAST);

    // Advance the prescaler and digit index; disabled scanning parks at slot 0.
    always_comb begin
        prescaler_d = prescaler_q + 1'b1;
        index_d     = index_q;
        if (!en) begin
            prescaler_d = '0;
            index_d     = '0;
        end else if (slot_end) begin
            prescaler_d = '0;
            index_d     = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
        end
    end

    // Scan position registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            prescaler_q <= '0;
            index_q     <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            index_q     <= index_d;
        end
    end

    // Capture loads: direct while dark or at a frame boundary, otherwise queued.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data registers are reset too, so a stale value can never reach the display after reset.
        if (rst) begin
            active_val_q <= '0;
            active_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
        end else if (!en) begin
            if (load) begin
                active_val_q <= value;
                active_dp_q  <= dp_mask;
                pend_flag_q  <= 1'b0;
            end
        end else if (frame_end) begin
            if (load) begin
                active_val_q <= value;
                active_dp_q  <= dp_mask;
            end else if (pend_flag_q) begin
                active_val_q <= pend_val_q;
                active_dp_q  <= pend_dp_q;
            end
            pend_flag_q <= 1'b0;
        end else if (load) begin
            pend_val_q  <= value;
            pend_dp_q   <= dp_mask;
            pend_flag_q <= 1'b1;
        end
    end

    // Select the current digit's nibble/dp and find whether it is a leading zero.
    always_comb begin
        logic zero_run;
        cur_nib  = active_val_q[3:0];
        cur_dp   = active_dp_q[0];
        lz_hit   = 1'b0;
        zero_run = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_q == IDX_W'(i)) begin
                cur_nib = active_val_q[4*i +: 4];
                cur_dp  = active_dp_q[i];
            end
        end
        // Walk from the most significant digit down; digit 0 is never blanked.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (active_val_q[4*i +: 4] == 4'h0);
            if (index_q == IDX_W'(i)) begin
                lz_hit = zero_run;
            end
        end
    end

    seg7_decode u_decode (
        .nibble_i   (cur_nib),
        .hex_mode_i (hex_mode),
        .seg_o      (dec_seg)
    );

    // Build the next segment/digit drive: dark during the blank interval.
    always_comb begin
        seg_d = SEG_OFF;
        dig_d = '1;
        if (en && (prescaler_q >= PRE_LIT)) begin
            dig_d[index_q]         = 1'b0;
            seg_d[SEG_BIT_A:SEG_BIT_G] = (lz_blank && lz_hit) ? 7'h00 : dec_seg;
            seg_d[SEG_BIT_DP]      = cur_dp;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q        <= SEG_OFF;
            dig_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_end;
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_disp_scan;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            load;
    logic [4*N-1:0]  value;
    logic [N-1:0]    dp_mask;
    logic            hex_mode;
    logic            lz_blank;
    logic [7:0]      seg;
    logic [N-1:0]    dig;
    logic            frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            hex;
        logic            lz;
        logic [3:0][7:0] exp_seg;   // [k] = expected seg for digit k
    } vec_t;

    vec_t vecs [8];

    disp_scan #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_mask    (dp_mask),
        .hex_mode   (hex_mode),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dig        (dig),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, got, exp);
        end
    endtask

    // Wait (bounded) for the falling edge on which frame_done is seen high.
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s wait_frame: frame_done not seen within 80 cycles, expected a pulse", tag);
        end
    endtask

    // Starting on the cycle frame_done is seen, check one whole frame and
    // the frame_done pulse that ends it.
    task automatic frame_body(input logic [3:0][7:0] exp, input string tag);
        logic [3:0] exp_dig;
        @(negedge clk);
        check($sformatf("%s blank dig", tag), {4'h0, dig}, 8'h0F);
        check($sformatf("%s blank seg", tag), seg, 8'h00);
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (k > 0) repeat (SD) @(negedge clk);
            exp_dig = ~(4'b0001 << k);
            check($sformatf("%s d%0d dig", tag, k), {4'h0, dig}, {4'h0, exp_dig});
            check($sformatf("%s d%0d seg", tag, k), seg, exp[k]);
        end
        repeat (5) @(negedge clk);
        check($sformatf("%s frame_done", tag), {7'h0, frame_done}, 8'h01);
    endtask

    initial begin
        int saw_1111;
        int bad;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b0, 32'h60DAF266};
        vecs[1] = '{16'h00A5, 4'b0000, 1'b0, 1'b1, 32'h000000B6};
        vecs[2] = '{16'h00A5, 4'b0000, 1'b1, 1'b1, 32'h0000EEB6};
        vecs[3] = '{16'h0000, 4'b0100, 1'b0, 1'b1, 32'h000100FC};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, 1'b0, 32'hFCFCFCFC};
        vecs[5] = '{16'hCDEF, 4'b1010, 1'b1, 1'b0, 32'h9D7A9F8E};
        vecs[6] = '{16'h0907, 4'b0001, 1'b0, 1'b1, 32'h00F6FCE1};
        vecs[7] = '{16'h8B60, 4'b0000, 1'b0, 1'b1, 32'hFE00BEFC};

        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp_mask  = '0;
        hex_mode = 1'b0;
        lz_blank = 1'b0;

        repeat (2) @(negedge clk);
        check("reset dig", {4'h0, dig}, 8'h0F);
        check("reset seg", seg, 8'h00);
        check("reset frame_done", {7'h0, frame_done}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;

        // Table: load mid-frame, new value shows from the following frame.
        for (int v = 0; v < 8; v++) begin
            hex_mode = vecs[v].hex;
            lz_blank = vecs[v].lz;
            value    = vecs[v].value;
            dp_mask  = vecs[v].dp;
            load     = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_frame($sformatf("vec%0d", v));
            frame_body(vecs[v].exp_seg, $sformatf("vec%0d", v));
        end

        // Two loads within one frame: old value held, last load wins.
        saw_1111 = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (dig != 4'hF && seg == 8'h60) saw_1111++;
            if (c == 27) check("lastwin old d3 seg", seg, 8'hFE);
            if (c == 32) check("lastwin frame_done", {7'h0, frame_done}, 8'h01);
            if (c == 5)  begin value = 16'h1111; load = 1'b1; end
            if (c == 6)  load = 1'b0;
            if (c == 12) begin value = 16'h2222; load = 1'b1; end
            if (c == 13) load = 1'b0;
        end
        frame_body(32'hDADADADA, "lastwin");
        check("lastwin 1111 never shown", saw_1111[7:0], 8'h00);

        // Load coinciding with the frame boundary shows from the next slot 0.
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (c == 27) check("boundary old d3 seg", seg, 8'hDA);
            if (c == 31) begin value = 16'h4321; load = 1'b1; end
        end
        @(negedge clk);
        load = 1'b0;
        lz_blank = 1'b0;
        check("boundary frame_done", {7'h0, frame_done}, 8'h01);
        frame_body(32'h66F2DA60, "boundary");

        // Drop en mid-slot, load while dark, then re-enable.
        repeat (5) @(negedge clk);
        check("en lit dig", {4'h0, dig}, 8'h0E);
        check("en lit seg", seg, 8'h60);
        en = 1'b0;
        @(negedge clk);
        check("en off dig", {4'h0, dig}, 8'h0F);
        check("en off seg", seg, 8'h00);
        check("en off frame_done", {7'h0, frame_done}, 8'h00);
        value = 16'h0005;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_done || dig != 4'hF || seg != 8'h00) bad++;
        end
        check("en off stays dark", bad[7:0], 8'h00);
        en = 1'b1;
        @(negedge clk);
        check("reen c1 dig", {4'h0, dig}, 8'h0F);
        @(negedge clk);
        check("reen c2 dig", {4'h0, dig}, 8'h0F);
        @(negedge clk);
        check("reen c3 dig", {4'h0, dig}, 8'h0E);
        check("reen c3 seg", seg, 8'hB6);

        // Asynchronous reset in the middle of a lit slot.
        repeat (2) @(negedge clk);
        check("prerst seg", seg, 8'hB6);
        rst = 1'b1;
        #1;
        check("async rst dig", {4'h0, dig}, 8'h0F);
        check("async rst seg", seg, 8'h00);
        check("async rst frame_done", {7'h0, frame_done}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst c1 dig", {4'h0, dig}, 8'h0F);
        repeat (2) @(negedge clk);
        check("post rst c3 dig", {4'h0, dig}, 8'h0E);
        check("post rst c3 seg", seg, 8'hFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
